main_fsm: RTL

MAIN_FSM -- requirements
Module: main_fsm

---
 rtl/main_fsm.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/main_fsm.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/writeback from the opcode.
// Latency: outputs are decoded from the state register only, so they change one clk after a transition. No backpressure.
// Reset: asynchronous active-low, forces Fetch and aborts any instruction in flight.
module main_fsm (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUOp,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                // Unsupported opcodes fall straight back to Fetch without touching any write enable.
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW) begin
                    state_d = S_MEMREAD;
                end else if (op == OP_SW) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Pure Moore decode: op never reaches an output, and illegal codes leave everything at 0.
    always_comb begin
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 2'b00;
        PCUpdate  = 1'b0;
        Branch    = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCUpdate  = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                PCUpdate = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                Branch  = 1'b1;
            end
            default: begin
                AdrSrc = 1'b0;
            end
        endcase
    end

    assign state = state_q;

endmodule
